// File: rtl/lock_arbiter.sv
// rtl/lock_arbiter.sv - round-robin arbiter with held (locked) one-hot grant and hold timeout
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   req[N]       level-sensitive request per requester
//   done[N]      completion pulse per requester; only done[owner] is honoured
//   grant[N]     registered one-hot (or all-zero) grant
//   busy         high while a grant is held (|grant)
//   owner[OW]    index of the current or most recent grantee
//   timeout_evt  one-cycle pulse in the first idle cycle after a forced release

module lock_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 16,
    parameter int OW      = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  done,
    output logic [N-1:0]  grant,
    output logic          busy,
    output logic [OW-1:0] owner,
    output logic          timeout_evt
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t        state, next_state;
    logic [N-1:0]  next_grant;
    logic [OW-1:0] next_owner;
    logic [OW-1:0] ptr, next_ptr;
    logic [CW-1:0] cnt, next_cnt;
    logic          next_tevt;

    // Rotate requests so bit 0 is the requester at ptr; the lowest set bit
    // of the rotated vector is then the round-robin winner.
    logic [2*N-1:0] req_dbl;
    logic [OW:0]    win_sum;
    logic [OW-1:0]  win;
    logic           found;

    assign req_dbl = {req, req} >> ptr;

    always_comb begin
        found   = 1'b0;
        win_sum = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (req_dbl[j]) begin
                found   = 1'b1;
                win_sum = {1'b0, ptr} + (OW+1)'(j);
            end
        end
        if (win_sum >= (OW+1)'(N)) begin
            win = OW'(win_sum - (OW+1)'(N));
        end else begin
            win = OW'(win_sum);
        end
    end

    always_comb begin
        next_state = state;
        next_grant = grant;
        next_owner = owner;
        next_ptr   = ptr;
        next_cnt   = cnt;
        next_tevt  = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    next_state = LOCKED;
                    next_grant = {{(N-1){1'b0}}, 1'b1} << win;
                    next_owner = win;
                    next_cnt   = '0;
                end
            end
            LOCKED: begin
                // done/req-drop take precedence over the hold limit so a
                // coincident completion is not reported as a timeout.
                if (done[owner] || !req[owner]) begin
                    next_state = IDLE;
                end else if (TIMEOUT != 0 && cnt == CNT_MAX) begin
                    next_state = IDLE;
                    next_tevt  = 1'b1;
                end else if (TIMEOUT != 0) begin
                    next_cnt = cnt + 1'b1;
                end
                if (next_state == IDLE) begin
                    next_grant = '0;
                    next_ptr   = (owner == OW'(N - 1)) ? '0 : owner + 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
                next_grant = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= '0;
            owner       <= '0;
            ptr         <= '0;
            cnt         <= '0;
            timeout_evt <= 1'b0;
        end else begin
            state       <= next_state;
            grant       <= next_grant;
            owner       <= next_owner;
            ptr         <= next_ptr;
            cnt         <= next_cnt;
            timeout_evt <= next_tevt;
        end
    end

    assign busy = |grant;

endmodule

// File: tb/tb_lock_arbiter.sv
// tb/tb_lock_arbiter.sv - directed self-checking bench for lock_arbiter

module tb_lock_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] done;

    logic [3:0] g16, g4;
    logic       b16, b4;
    logic [1:0] o16, o4;
    logic       t16, t4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lock_arbiter #(.N(4), .TIMEOUT(16)) u_dut16 (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .grant(g16), .busy(b16), .owner(o16), .timeout_evt(t16)
    );

    lock_arbiter #(.N(4), .TIMEOUT(4)) u_dut4 (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .grant(g4), .busy(b4), .owner(o4), .timeout_evt(t4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        req  = 4'b0000;
        done = 4'b0000;

        // reset then single request
        do_reset();
        check("rst_grant", 32'(g16), 32'h0);
        check("rst_busy", 32'(b16), 32'h0);
        check("rst_owner", 32'(o16), 32'h0);
        check("rst_tevt", 32'(t16), 32'h0);
        req = 4'b0100;
        tick();
        check("single_grant", 32'(g16), 32'b0100);
        check("single_owner", 32'(o16), 32'd2);
        check("single_busy", 32'(b16), 32'h1);
        req = 4'b0000;
        tick();
        check("single_release", 32'(g16), 32'h0);
        check("single_owner_hold", 32'(o16), 32'd2);

        // round-robin fairness
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("rr_grant", 32'(g16), 32'(4'b0001 << (k % 4)));
            check("rr_owner", 32'(o16), 32'(k % 4));
            tick();
            tick();
            done = 4'b0001 << (k % 4);
            tick();
            done = 4'b0000;
            check("rr_bubble", 32'(g16), 32'h0);
            check("rr_no_tevt", 32'(t4), 32'h0);
        end
        req = 4'b0000;
        tick();

        // lock hold: non-owner requests wait, next grant skips idle req[2]
        do_reset();
        req = 4'b0010;
        tick();
        check("hold_grant", 32'(g16), 32'b0010);
        req = 4'b1011;
        tick();
        check("hold_keep1", 32'(g16), 32'b0010);
        tick();
        check("hold_keep2", 32'(g16), 32'b0010);
        done = 4'b0010;
        tick();
        done = 4'b0000;
        check("hold_release", 32'(g16), 32'h0);
        tick();
        check("hold_next", 32'(g16), 32'b1000);
        check("hold_next_owner", 32'(o16), 32'd3);
        req = 4'b0000;
        tick();

        // timeout with TIMEOUT=4
        do_reset();
        req = 4'b0001;
        for (int c = 1; c <= 4; c++) begin
            tick();
            check("to_held", 32'(g4), 32'b0001);
            check("to_tevt_low", 32'(t4), 32'h0);
        end
        tick();
        check("to_revoked", 32'(g4), 32'h0);
        check("to_tevt", 32'(t4), 32'h1);
        check("to16_still", 32'(g16), 32'b0001);
        tick();
        check("to_regrant", 32'(g4), 32'b0001);
        check("to_tevt_pulse", 32'(t4), 32'h0);

        // done coincident with limit on the regrant
        tick();
        tick();
        tick();
        check("co_c4", 32'(g4), 32'b0001);
        done = 4'b0001;
        tick();
        done = 4'b0000;
        check("co_release", 32'(g4), 32'h0);
        check("co_no_tevt", 32'(t4), 32'h0);
        req = 4'b0000;
        tick();

        // reset mid-grant, then request drop
        do_reset();
        req = 4'b1000;
        tick();
        check("mr_grant", 32'(g16), 32'b1000);
        rst = 1'b1;
        req = 4'b1001;
        tick();
        rst = 1'b0;
        check("mr_grant0", 32'(g16), 32'h0);
        check("mr_owner0", 32'(o16), 32'h0);
        check("mr_busy0", 32'(b16), 32'h0);
        check("mr_tevt0", 32'(t4), 32'h0);
        tick();
        check("mr_ptr0_grant", 32'(g16), 32'b0001);
        req = 4'b1000;
        tick();
        check("drop_release", 32'(g16), 32'h0);
        check("drop_no_tevt", 32'(t16), 32'h0);
        tick();
        check("drop_next", 32'(g16), 32'b1000);
        check("drop_next_owner", 32'(o16), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lock_arbiter.md
# lock_arbiter

Round-robin arbiter with ownership lock that shares one resource among N requesters. A granted requester keeps exclusive ownership until it signals completion, drops its request, or exceeds a maximum hold time. The block sits in front of the shared datapath and replaces the stateless fixed-priority grant with a fair, held grant. Its one-hot grant output drives the datapath's select and enable logic directly.

## Interface
- N, default 4: number of requesters, 2..16.
- TIMEOUT, default 16: maximum consecutive cycles a grant is held. 0 disables the timeout.
- OW, default $clog2(N): width of the owner index.

- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N  request per requester, level-sensitive.
- done  in  N  completion pulse per requester. Only done[owner] is honoured.
- grant  out  N  one-hot (or all-zero) registered grant.
- busy  out  1  high while a grant is held. Equals |grant.
- owner  out  OW  index of the current or most recent grantee.
- timeout_evt  out  1  one-cycle pulse when a grant is forcibly revoked.

## Operation
- Two states:
  - IDLE: grant=0.
  - LOCKED: exactly one grant bit set.
- Reset values:
  - State IDLE; grant=0, busy=0, owner=0, timeout_evt=0.
  - Round-robin pointer ptr=0; hold counter cnt=0.
- IDLE → LOCKED:
  - Transition happens when req≠0.
  - Winner is the first set req bit scanning ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - The winner's grant bit and owner are registered; cnt is cleared.
- LOCKED → IDLE on the first of these conditions:
  - done[owner]=1.
  - req[owner]=0.
  - TIMEOUT≠0 and cnt==TIMEOUT-1 with neither of the above true. This is the timeout case: timeout_evt is set for the next cycle.
- On every release, ptr is set to (owner+1) mod N. The releasing requester therefore gets lowest priority in the next arbitration.
- In LOCKED:
  - cnt increments by 1 per cycle and saturates at TIMEOUT-1.
  - Changes on non-owner req bits are ignored; those requests wait.
  - done on non-owner bits is ignored.
- owner holds its value through IDLE and only updates on a new grant.
- timeout_evt is high for exactly one cycle, the first IDLE cycle after a timeout release.
- If done[owner] and the timeout limit coincide, the release is treated as normal and timeout_evt stays 0.
- rst asserted in any state, including mid-grant: next cycle returns to the reset values. No timeout_evt is generated.

## Timing
- Grant latency is 1 cycle: req sampled in IDLE at edge t gives grant high after edge t+1.
- Release latency is 1 cycle: done[owner] or req[owner] low sampled at edge t gives grant=0 after edge t+1.
- One mandatory IDLE cycle separates consecutive grants. Two grants are never adjacent, which gives the datapath a bubble for switchover.
- Maximum hold: with TIMEOUT=T>0, grant is high for at most T consecutive cycles.
- Worst-case wait for a continuously requesting requester is (N-1)·(T+1) cycles after the current grant ends.
- All outputs are registered; there is no combinational path from req or done to grant.

## Test plan
- Reset then single request:
  - Stimulus: rst for 2 cycles, then req=4'b0100 held, done=0, TIMEOUT=16.
  - Response: grant=4'b0100 one cycle after req is sampled, owner=2, busy=1.
- Round-robin fairness:
  - Stimulus: req=4'b1111 held; each owner pulses done 3 cycles after its grant.
  - Response: grant sequence 0001 → 0010 → 0100 → 1000 → 0001, with one all-zero cycle between each.
- Lock hold:
  - Stimulus: owner 1 granted; req[0] and req[3] asserted mid-grant.
  - Response: grant stays 4'b0010 until done[1]. The next grant is 4'b0100-free, i.e. 4'b1000, because ptr=2 and req[2]=0.
- Timeout:
  - Stimulus: TIMEOUT=4; req=4'b0001 held, done never asserted.
  - Response: grant high exactly 4 cycles. Then grant=0 with timeout_evt=1 for 1 cycle. Regrant to 0 follows after the IDLE cycle.
- Coincident done at limit:
  - Stimulus: TIMEOUT=4; done[owner] pulsed in the 4th grant cycle.
  - Response: release occurs and timeout_evt stays 0.
- Reset mid-grant and request drop:
  - Stimulus: rst asserted while grant=4'b1000; separately, owner drops req with no done.
  - Response: after rst, grant=0, owner=0, ptr=0, and req=4'b1001 grants 4'b0001 first. After the req drop, grant clears 1 cycle later.
